mem_refill_arbiter: RTL
=======================

# mem_refill_arbiter

Miss-refill controller that shares the single 128-bit main-memory port between the instruction-cache and data-cache refill paths of the five-stage MIPS pipeline. It sits between the two cache miss interfaces and external memory. It arbitrates round-robin, sequences dirty-line write-back before data refill, returns refill lines with a one-cycle done pulse, and drives the global pipeline stall that freezes the PC and all pipeline registers.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width (bits); line offset = log2(LINE_W/8) = 4
- CNT_W, 16, width of saturating miss counters
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous, active-high reset (sampled on clk; port name kept for codebase consistency)
- i_ic_miss  in  1  icache refill request, level, held until o_ic_done
- i_ic_addr  in  ADDR_W  icache miss address
- o_ic_data  out  LINE_W  refill line, valid while o_ic_done=1
- o_ic_done  out  1  one-cycle completion pulse
- i_dc_miss  in  1  dcache refill request, level, held until o_dc_done
- i_dc_addr  in  ADDR_W  dcache miss address
- i_dc_dirty  in  1  victim line dirty, write-back required first
- i_dc_wb_addr  in  ADDR_W  victim address
- i_dc_wb_data  in  LINE_W  victim line
- o_dc_data  out  LINE_W  refill line, valid while o_dc_done=1
- o_dc_done  out  1  one-cycle completion pulse
- o_mem_req, o_mem_we  out  1  memory request / write enable
- o_mem_addr  out  ADDR_W  line-aligned address ({addr[ADDR_W-1:4],4'b0})
- o_mem_wdata  out  LINE_W  write line
- i_mem_ack  in  1  memory completion; read data valid in the same cycle
- i_mem_rdata  in  LINE_W  read line
- o_stall  out  1  pipeline freeze
- o_ic_miss_cnt, o_dc_miss_cnt  out  CNT_W  saturating granted-miss counters

## Operation
- FSM states: IDLE, DC_WB, DC_FILL, IC_FILL, DONE.
- IDLE: if any miss is pending, the arbiter grants one. Both pending: grant the side not granted last; the last-grant flag resets to IC, so DC wins the first tie.
  - DC granted with i_dc_dirty=1 -> DC_WB.
  - DC granted with i_dc_dirty=0 -> DC_FILL.
  - IC granted -> IC_FILL.
  - Granted miss counter increments and saturates at 2^CNT_W-1.
- DC_WB: req=1, we=1, addr=wb_addr, wdata=wb_data. On ack -> DC_FILL.
- DC_FILL / IC_FILL: req=1, we=0, addr = miss address. On ack, capture i_mem_rdata into the line register -> DONE.
- DONE: assert the matching done pulse with data valid, then -> IDLE.
- Request fields (addr, we, wdata) are registered at state entry and held stable while req=1.
- o_stall = i_ic_miss | i_dc_miss | (state != IDLE).
- If a requester drops its miss before done (protocol violation), the transaction still completes and done still pulses.
- Inactive o_*_data holds its last value. Only done qualifies data.

## Timing
- Reset values: state IDLE; o_mem_req/we/addr/wdata = 0; both done = 0; both data = 0; counters = 0; last-grant = IC.
- Miss seen in IDLE at cycle N -> o_mem_req=1 at N+1.
- Ack at cycle M (fill) -> done=1 at M+1 -> IDLE at M+2; the earliest next o_mem_req is M+3.
- DC_WB ack at M -> DC_FILL req continues at M+1 with we=0 and the new address. req does not drop between the two phases.
- req deasserts the cycle after a fill ack. Ack while req=0 is ignored.
- Zero-wait memory (ack in the first req cycle): clean fill takes 3 cycles from miss to done (N+1 req/ack, N+2 done).
- Reset in any state: a transaction abandons within one cycle and memory must tolerate req dropping. No done is issued for it.
- Simultaneous miss and done for the same requester (new miss asserted in the done cycle): treat it as a new request in IDLE.

## Structure
- Package mips_mem_pkg: state enum (refill_state_t), LINE_W, LINE_OFF=4, line_align() function. Shared with the caches.
- Sub-module rr_arb2: two-requester round-robin arbiter (req[1:0], advance, gnt[1:0], last-grant register). It is reused later for the writeback buffer.
- Top-level: FSM, request registers, line capture register, counters.

## Test plan
- Single IC miss, addr 0x0040_0024, ack after 3 cycles, rdata 0xDEAD…BEEF -> o_mem_addr 0x0040_0020, we=0. o_ic_done one cycle with that line. o_ic_miss_cnt=1. o_stall low after done.
- Dirty DC miss: wb_addr 0x1000_0010, miss 0x2000_0008 -> write req 0x1000_0010 we=1, then read 0x2000_0000 with req held continuously. o_dc_done after the second ack.
- IC and DC asserted in the same cycle from reset -> DC served first, then IC. Back-to-back reissue alternates DC/IC/DC.
- Zero-wait memory (ack tied high) -> miss at N, done at N+2, o_stall high N through N+2.
- Reset asserted mid DC_FILL -> next cycle req=0, no done, counters 0, FSM in IDLE. The re-asserted miss is served normally.
- Force o_dc_miss_cnt to 0xFFFE, issue 3 misses -> counter 0xFFFF and holds.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-refill types and helpers for the MIPS cache refill path.
// The instruction and data caches use the same line geometry.
package mips_mem_pkg;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int LINE_OFF = 4;

  typedef enum logic [2:0] {
    IDLE,
    DC_WB,
    DC_FILL,
    IC_FILL,
    DONE
  } refill_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
  endfunction
endpackage

// File: rtl/mem_refill_arbiter_if.sv
// Bundle of cache-miss, main-memory and status signals around the refill arbiter.
// The master modport is the arbiter; the slave modport is the caches plus memory.
interface mem_refill_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              i_ic_miss;
  logic [ADDR_W-1:0] i_ic_addr;
  logic [LINE_W-1:0] o_ic_data;
  logic              o_ic_done;

  logic              i_dc_miss;
  logic [ADDR_W-1:0] i_dc_addr;
  logic              i_dc_dirty;
  logic [ADDR_W-1:0] i_dc_wb_addr;
  logic [LINE_W-1:0] i_dc_wb_data;
  logic [LINE_W-1:0] o_dc_data;
  logic              o_dc_done;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [LINE_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [LINE_W-1:0] i_mem_rdata;

  logic              o_stall;
  logic [CNT_W-1:0]  o_ic_miss_cnt;
  logic [CNT_W-1:0]  o_dc_miss_cnt;

  modport master (
    input  i_ic_miss, i_ic_addr,
    output o_ic_data, o_ic_done,
    input  i_dc_miss, i_dc_addr, i_dc_dirty, i_dc_wb_addr, i_dc_wb_data,
    output o_dc_data, o_dc_done,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_stall, o_ic_miss_cnt, o_dc_miss_cnt
  );

  modport slave (
    output i_ic_miss, i_ic_addr,
    input  o_ic_data, o_ic_done,
    output i_dc_miss, i_dc_addr, i_dc_dirty, i_dc_wb_addr, i_dc_wb_data,
    input  o_dc_data, o_dc_done,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_stall, o_ic_miss_cnt, o_dc_miss_cnt
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side not granted last wins.
// The last-grant flag moves only when the caller accepts a grant via i_advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (i_advance && (|o_gnt)) begin
      r_last <= o_gnt[1];
    end
  end
endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the single main-memory line port between icache and dcache refills,
// sequencing dirty write-back before the data refill and freezing the pipeline.
module mem_refill_arbiter
  import mips_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_refill_arbiter_if.master bus
);
  refill_state_t r_state, w_next;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_adv;
  logic              w_ack;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              r_ic_done;
  logic              r_dc_done;
  logic [LINE_W-1:0] r_ic_data;
  logic [LINE_W-1:0] r_dc_data;
  logic [CNT_W-1:0]  r_ic_cnt;
  logic [CNT_W-1:0]  r_dc_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_req = {bus.i_dc_miss, bus.i_ic_miss};
  assign w_ack = bus.i_mem_ack & r_mem_req;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rstn),
    .i_req     (w_req),
    .i_advance (w_adv),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rstn) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt[1]) begin
          w_adv  = 1'b1;
          w_next = bus.i_dc_dirty ? DC_WB : DC_FILL;
        end else if (w_gnt[0]) begin
          w_adv  = 1'b1;
          w_next = IC_FILL;
        end
      end
      DC_WB:            if (w_ack) w_next = DC_FILL;
      DC_FILL, IC_FILL: if (w_ack) w_next = DONE;
      DONE:             w_next = IDLE;
      default:          w_next = IDLE;
    endcase
  end

  // Request fields are loaded on state entry so memory sees them stable while req=1.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_done   <= 1'b0;
      r_dc_done   <= 1'b0;
      r_ic_data   <= '0;
      r_dc_data   <= '0;
    end else begin
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_next == DC_WB) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= line_align(bus.i_dc_wb_addr);
            r_mem_wdata <= bus.i_dc_wb_data;
          end else if (w_next == DC_FILL) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= line_align(bus.i_dc_addr);
          end else if (w_next == IC_FILL) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= line_align(bus.i_ic_addr);
          end
        end
        DC_WB: begin
          if (w_ack) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= line_align(bus.i_dc_addr);
          end
        end
        DC_FILL: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_dc_data <= bus.i_mem_rdata;
            r_dc_done <= 1'b1;
          end
        end
        IC_FILL: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_ic_data <= bus.i_mem_rdata;
            r_ic_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_ic_cnt <= '0;
      r_dc_cnt <= '0;
    end else if (w_adv) begin
      if (w_gnt[1]) r_dc_cnt <= sat_inc(r_dc_cnt);
      else          r_ic_cnt <= sat_inc(r_ic_cnt);
    end
  end

  assign bus.o_mem_req     = r_mem_req;
  assign bus.o_mem_we      = r_mem_we;
  assign bus.o_mem_addr    = r_mem_addr;
  assign bus.o_mem_wdata   = r_mem_wdata;
  assign bus.o_ic_done     = r_ic_done;
  assign bus.o_dc_done     = r_dc_done;
  assign bus.o_ic_data     = r_ic_data;
  assign bus.o_dc_data     = r_dc_data;
  assign bus.o_ic_miss_cnt = r_ic_cnt;
  assign bus.o_dc_miss_cnt = r_dc_cnt;
  assign bus.o_stall       = bus.i_ic_miss | bus.i_dc_miss | (r_state != IDLE);
endmodule
